// File: rtl/store_queue.sv
// rtl/store_queue.sv - circular store queue with commit, drain and store-to-load forwarding
module store_queue #(
    parameter int XLEN          = 32,
    parameter int ROB_TAG_WIDTH = 32,
    parameter int STQ_SIZE      = 16,
    parameter int IDX_W         = $clog2(STQ_SIZE)
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     alloc_valid,
    input  logic [ROB_TAG_WIDTH-1:0] alloc_rob_tag,
    output logic                     alloc_ready,
    output logic [IDX_W-1:0]         alloc_index,
    input  logic                     addr_valid,
    input  logic [IDX_W-1:0]         addr_index,
    input  logic [XLEN-1:0]          addr_value,
    input  logic                     data_valid_in,
    input  logic [IDX_W-1:0]         data_index,
    input  logic [XLEN-1:0]          data_value,
    input  logic                     commit_valid,
    input  logic                     flush,
    output logic                     mem_req_valid,
    output logic [XLEN-1:0]          mem_req_addr,
    output logic [XLEN-1:0]          mem_req_data,
    input  logic                     mem_req_ready,
    input  logic [XLEN-1:0]          fwd_addr,
    input  logic [STQ_SIZE-1:0]      fwd_mask,
    output logic                     fwd_hit,
    output logic [XLEN-1:0]          fwd_data,
    output logic                     fwd_stall,
    output logic                     full,
    output logic                     empty
);

    // per-entry state; flags packed so the forward search can use vector ops
    logic [STQ_SIZE-1:0]      ent_valid;
    logic [STQ_SIZE-1:0]      ent_addr_valid;
    logic [STQ_SIZE-1:0]      ent_data_valid;
    logic [STQ_SIZE-1:0]      ent_committed;
    logic [XLEN-1:0]          ent_addr   [STQ_SIZE];
    logic [XLEN-1:0]          ent_data   [STQ_SIZE];
    logic [ROB_TAG_WIDTH-1:0] ent_rob_tag[STQ_SIZE];

    logic [IDX_W-1:0] head;
    logic [IDX_W-1:0] commit_ptr;
    logic [IDX_W-1:0] tail;
    logic [IDX_W:0]   count;

    logic             alloc_fire;
    logic             drain_fire;
    logic             commit_fire;
    logic [IDX_W:0]   committed_cnt;

    assign full        = (count == (IDX_W+1)'(STQ_SIZE));
    assign empty       = (count == '0);
    assign alloc_ready = !full;
    assign alloc_index = tail;

    assign mem_req_valid = ent_valid[head] && ent_committed[head];
    assign mem_req_addr  = ent_addr[head];
    assign mem_req_data  = ent_data[head];

    assign alloc_fire  = alloc_valid && alloc_ready;
    assign drain_fire  = mem_req_valid && mem_req_ready;
    // the committed check stops a re-commit when the queue is full of committed stores
    assign commit_fire = commit_valid && ent_valid[commit_ptr] && !ent_committed[commit_ptr];

    // number of committed entries, which are exactly the survivors of a flush
    always_comb begin
        committed_cnt = '0;
        for (int i = 0; i < STQ_SIZE; i++) begin
            committed_cnt = committed_cnt + (IDX_W+1)'(ent_valid[i] && ent_committed[i]);
        end
    end

    // entry, pointer and count update; the drain clear is last so it wins on the head entry
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ent_valid      <= '0;
            ent_addr_valid <= '0;
            ent_data_valid <= '0;
            ent_committed  <= '0;
            for (int i = 0; i < STQ_SIZE; i++) begin
                ent_addr[i]    <= '0;
                ent_data[i]    <= '0;
                ent_rob_tag[i] <= '0;
            end
            head       <= '0;
            commit_ptr <= '0;
            tail       <= '0;
            count      <= '0;
        end else begin
            if (flush) begin
                for (int i = 0; i < STQ_SIZE; i++) begin
                    if (ent_valid[i] && !ent_committed[i]) begin
                        ent_valid[i]      <= 1'b0;
                        ent_addr_valid[i] <= 1'b0;
                        ent_data_valid[i] <= 1'b0;
                    end
                end
                tail  <= commit_ptr;
                count <= committed_cnt - (IDX_W+1)'(drain_fire);
            end else begin
                if (alloc_fire) begin
                    ent_valid[tail]      <= 1'b1;
                    ent_addr_valid[tail] <= 1'b0;
                    ent_data_valid[tail] <= 1'b0;
                    ent_committed[tail]  <= 1'b0;
                    ent_rob_tag[tail]    <= alloc_rob_tag;
                    tail                 <= tail + IDX_W'(1);
                end
                if (addr_valid && ent_valid[addr_index]) begin
                    ent_addr[addr_index]       <= addr_value;
                    ent_addr_valid[addr_index] <= 1'b1;
                end
                if (data_valid_in && ent_valid[data_index]) begin
                    ent_data[data_index]       <= data_value;
                    ent_data_valid[data_index] <= 1'b1;
                end
                if (commit_fire) begin
                    ent_committed[commit_ptr] <= 1'b1;
                    commit_ptr                <= commit_ptr + IDX_W'(1);
                end
                count <= count + (IDX_W+1)'(alloc_fire) - (IDX_W+1)'(drain_fire);
            end
            if (drain_fire) begin
                ent_valid[head]      <= 1'b0;
                ent_addr_valid[head] <= 1'b0;
                ent_data_valid[head] <= 1'b0;
                ent_committed[head]  <= 1'b0;
                head                 <= head + IDX_W'(1);
            end
        end
    end

    logic [STQ_SIZE-1:0] fwd_cand;
    logic                fwd_found;
    logic [IDX_W-1:0]    fwd_sel;
    logic [IDX_W-1:0]    fwd_idx;
    logic                fwd_unknown;

    // youngest matching older store, scanning backwards from the newest allocation
    always_comb begin
        fwd_found   = 1'b0;
        fwd_sel     = '0;
        fwd_idx     = '0;
        fwd_unknown = |(fwd_mask & ent_valid & ~ent_addr_valid);
        for (int i = 0; i < STQ_SIZE; i++) begin
            fwd_cand[i] = fwd_mask[i] && ent_valid[i] && ent_addr_valid[i] &&
                          (ent_addr[i][XLEN-1:2] == fwd_addr[XLEN-1:2]);
        end
        for (int i = 0; i < STQ_SIZE; i++) begin
            fwd_idx = tail - IDX_W'(i + 1);
            if (!fwd_found && fwd_cand[fwd_idx]) begin
                fwd_found = 1'b1;
                fwd_sel   = fwd_idx;
            end
        end
        fwd_stall = fwd_unknown || (fwd_found && !ent_data_valid[fwd_sel]);
        fwd_hit   = fwd_found && ent_data_valid[fwd_sel] && !fwd_stall;
        fwd_data  = fwd_hit ? ent_data[fwd_sel] : '0;
    end

endmodule

// File: tb/tb_store_queue.sv
// tb/tb_store_queue.sv - self-checking bench for store_queue with a drain scoreboard
module tb_store_queue;

    localparam int XLEN  = 32;
    localparam int TW    = 32;
    localparam int N     = 16;
    localparam int IW    = 4;

    logic            clk = 1'b0;
    logic            reset_n;
    logic            alloc_valid;
    logic [TW-1:0]   alloc_rob_tag;
    logic            alloc_ready;
    logic [IW-1:0]   alloc_index;
    logic            addr_valid;
    logic [IW-1:0]   addr_index;
    logic [XLEN-1:0] addr_value;
    logic            data_valid_in;
    logic [IW-1:0]   data_index;
    logic [XLEN-1:0] data_value;
    logic            commit_valid;
    logic            flush;
    logic            mem_req_valid;
    logic [XLEN-1:0] mem_req_addr;
    logic [XLEN-1:0] mem_req_data;
    logic            mem_req_ready;
    logic [XLEN-1:0] fwd_addr;
    logic [N-1:0]    fwd_mask;
    logic            fwd_hit;
    logic [XLEN-1:0] fwd_data;
    logic            fwd_stall;
    logic            full;
    logic            empty;

    int checks = 0;
    int errors = 0;

    // expected drain order: {addr, data} pushed at commit, popped at handshake
    logic [2*XLEN-1:0] sb[$];
    logic [2*XLEN-1:0] exp_req;

    store_queue #(.XLEN(XLEN), .ROB_TAG_WIDTH(TW), .STQ_SIZE(N)) dut (
        .clk(clk), .reset_n(reset_n),
        .alloc_valid(alloc_valid), .alloc_rob_tag(alloc_rob_tag),
        .alloc_ready(alloc_ready), .alloc_index(alloc_index),
        .addr_valid(addr_valid), .addr_index(addr_index), .addr_value(addr_value),
        .data_valid_in(data_valid_in), .data_index(data_index), .data_value(data_value),
        .commit_valid(commit_valid), .flush(flush),
        .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr),
        .mem_req_data(mem_req_data), .mem_req_ready(mem_req_ready),
        .fwd_addr(fwd_addr), .fwd_mask(fwd_mask), .fwd_hit(fwd_hit),
        .fwd_data(fwd_data), .fwd_stall(fwd_stall), .full(full), .empty(empty)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        alloc_valid = 0; alloc_rob_tag = '0;
        addr_valid = 0; addr_index = '0; addr_value = '0;
        data_valid_in = 0; data_index = '0; data_value = '0;
        commit_valid = 0; flush = 0; mem_req_ready = 0;
        fwd_addr = '0; fwd_mask = '0;
        sb.delete();
        step(); step();
        reset_n = 1'b1;
        step();
    endtask

    task automatic alloc_n(input int n, input int tag0);
        for (int i = 0; i < n; i++) begin
            alloc_valid = 1; alloc_rob_tag = TW'(tag0 + i);
            step();
        end
        alloc_valid = 0;
    endtask

    task automatic write_ad(input int idx, input logic [XLEN-1:0] a, input logic [XLEN-1:0] d,
                            input bit with_data);
        addr_valid = 1; addr_index = IW'(idx); addr_value = a;
        data_valid_in = with_data; data_index = IW'(idx); data_value = d;
        step();
        addr_valid = 0; data_valid_in = 0;
    endtask

    task automatic commit_push(input logic [XLEN-1:0] a, input logic [XLEN-1:0] d);
        commit_valid = 1;
        sb.push_back({a, d});
        step();
        commit_valid = 0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (alloc_ready !== 1'b1) begin errors++; $display("FAIL reset_alloc_ready got %0b want 1", alloc_ready); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got %0b want 0", full); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %0b want 1", empty); end
        checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_mem_req_valid got %0b want 0", mem_req_valid); end
        checks++; if (fwd_hit !== 1'b0 || fwd_stall !== 1'b0) begin errors++; $display("FAIL reset_fwd got hit=%0b stall=%0b want 0/0", fwd_hit, fwd_stall); end
        checks++; if (alloc_index !== '0) begin errors++; $display("FAIL reset_alloc_index got %0d want 0", alloc_index); end
    endtask

    task automatic test_fill();
        do_reset();
        for (int i = 0; i < N; i++) begin
            checks++; if (alloc_index !== IW'(i)) begin errors++; $display("FAIL fill_index got %0d want %0d", alloc_index, i); end
            alloc_valid = 1; alloc_rob_tag = TW'(i);
            step();
        end
        checks++; if (full !== 1'b1 || alloc_ready !== 1'b0) begin errors++; $display("FAIL fill_full got full=%0b ready=%0b want 1/0", full, alloc_ready); end
        alloc_rob_tag = TW'(16);
        step();
        alloc_valid = 0;
        checks++; if (full !== 1'b1 || empty !== 1'b0 || alloc_index !== '0) begin errors++; $display("FAIL fill_overflow got full=%0b empty=%0b idx=%0d want 1/0/0", full, empty, alloc_index); end
    endtask

    task automatic test_drain();
        do_reset();
        alloc_n(1, 1);
        write_ad(0, 32'h100, 32'hDEADBEEF, 1'b1);
        commit_push(32'h100, 32'hDEADBEEF);
        exp_req = sb.pop_front();
        for (int c = 0; c < 3; c++) begin
            checks++; if (mem_req_valid !== 1'b1 || {mem_req_addr, mem_req_data} !== exp_req) begin
                errors++; $display("FAIL drain_hold cyc %0d got v=%0b %h/%h want 1 %h", c, mem_req_valid, mem_req_addr, mem_req_data, exp_req); end
            step();
        end
        mem_req_ready = 1;
        step();
        mem_req_ready = 0;
        checks++; if (empty !== 1'b1 || mem_req_valid !== 1'b0) begin errors++; $display("FAIL drain_empty got empty=%0b v=%0b want 1/0", empty, mem_req_valid); end
    endtask

    task automatic test_forward();
        do_reset();
        alloc_n(4, 0);
        write_ad(0, 32'h200, 32'h11, 1'b1);
        write_ad(1, 32'h200, 32'h22, 1'b1);
        write_ad(2, 32'h300, 32'h0, 1'b0);
        fwd_addr = 32'h202; fwd_mask = 16'b0011; #1;
        checks++; if (fwd_hit !== 1'b1 || fwd_stall !== 1'b0 || fwd_data !== 32'h22) begin errors++; $display("FAIL fwd_youngest got hit=%0b stall=%0b data=%h want 1/0/22", fwd_hit, fwd_stall, fwd_data); end
        fwd_mask = 16'b0001; #1;
        checks++; if (fwd_hit !== 1'b1 || fwd_data !== 32'h11) begin errors++; $display("FAIL fwd_older got hit=%0b data=%h want 1/11", fwd_hit, fwd_data); end
        fwd_addr = 32'h300; fwd_mask = 16'b0100; #1;
        checks++; if (fwd_stall !== 1'b1 || fwd_hit !== 1'b0 || fwd_data !== '0) begin errors++; $display("FAIL fwd_nodata got stall=%0b hit=%0b data=%h want 1/0/0", fwd_stall, fwd_hit, fwd_data); end
        fwd_addr = 32'h200; fwd_mask = 16'b1011; #1;
        checks++; if (fwd_stall !== 1'b1 || fwd_hit !== 1'b0) begin errors++; $display("FAIL fwd_unknown_addr got stall=%0b hit=%0b want 1/0", fwd_stall, fwd_hit); end
        fwd_addr = 32'h400; fwd_mask = 16'b0111; #1;
        checks++; if (fwd_stall !== 1'b0 || fwd_hit !== 1'b0 || fwd_data !== '0) begin errors++; $display("FAIL fwd_miss got stall=%0b hit=%0b data=%h want 0/0/0", fwd_stall, fwd_hit, fwd_data); end
        fwd_mask = '0;
    endtask

    task automatic test_flush();
        do_reset();
        alloc_n(5, 20);
        write_ad(0, 32'h1000, 32'hA0, 1'b1);
        write_ad(1, 32'h1004, 32'hA1, 1'b1);
        write_ad(2, 32'h1008, 32'hA2, 1'b1);
        commit_push(32'h1000, 32'hA0);
        commit_push(32'h1004, 32'hA1);
        exp_req = sb.pop_front();
        checks++; if (mem_req_valid !== 1'b1 || {mem_req_addr, mem_req_data} !== exp_req) begin errors++; $display("FAIL flush_head0 got v=%0b %h/%h want 1 %h", mem_req_valid, mem_req_addr, mem_req_data, exp_req); end
        flush = 1; mem_req_ready = 1;
        step();
        flush = 0; mem_req_ready = 0;
        checks++; if (alloc_index !== IW'(2) || empty !== 1'b0 || full !== 1'b0) begin errors++; $display("FAIL flush_tail got idx=%0d empty=%0b full=%0b want 2/0/0", alloc_index, empty, full); end
        fwd_addr = 32'h1008; fwd_mask = 16'b11100; #1;
        checks++; if (fwd_stall !== 1'b0 || fwd_hit !== 1'b0) begin errors++; $display("FAIL flush_invalid got stall=%0b hit=%0b want 0/0", fwd_stall, fwd_hit); end
        fwd_mask = '0;
        exp_req = sb.pop_front();
        checks++; if (mem_req_valid !== 1'b1 || {mem_req_addr, mem_req_data} !== exp_req) begin errors++; $display("FAIL flush_head1 got v=%0b %h/%h want 1 %h", mem_req_valid, mem_req_addr, mem_req_data, exp_req); end
        mem_req_ready = 1;
        step();
        mem_req_ready = 0;
        checks++; if (empty !== 1'b1 || mem_req_valid !== 1'b0) begin errors++; $display("FAIL flush_count got empty=%0b v=%0b want 1/0", empty, mem_req_valid); end
    endtask

    task automatic test_wrap();
        do_reset();
        alloc_n(N, 40);
        for (int i = 0; i < 4; i++) write_ad(i, XLEN'(32'h2000 + 16 * i), XLEN'(32'hC0 + i), 1'b1);
        for (int i = 0; i < 4; i++) commit_push(XLEN'(32'h2000 + 16 * i), XLEN'(32'hC0 + i));
        mem_req_ready = 1;
        for (int i = 0; i < 4; i++) begin
            exp_req = sb.pop_front();
            checks++; if (mem_req_valid !== 1'b1 || {mem_req_addr, mem_req_data} !== exp_req) begin errors++; $display("FAIL wrap_drain %0d got v=%0b %h/%h want 1 %h", i, mem_req_valid, mem_req_addr, mem_req_data, exp_req); end
            step();
        end
        mem_req_ready = 0;
        checks++; if (full !== 1'b0 || alloc_index !== '0) begin errors++; $display("FAIL wrap_after_drain got full=%0b idx=%0d want 0/0", full, alloc_index); end
        alloc_n(4, 60);
        checks++; if (full !== 1'b1 || alloc_index !== IW'(4)) begin errors++; $display("FAIL wrap_tail got full=%0b idx=%0d want 1/4", full, alloc_index); end
        write_ad(15, 32'h500, 32'hAA, 1'b1);
        write_ad(1, 32'h500, 32'hBB, 1'b1);
        fwd_addr = 32'h501; fwd_mask = 16'h8002; #1;
        checks++; if (fwd_hit !== 1'b1 || fwd_stall !== 1'b0 || fwd_data !== 32'hBB) begin errors++; $display("FAIL wrap_fwd_young got hit=%0b stall=%0b data=%h want 1/0/bb", fwd_hit, fwd_stall, fwd_data); end
        fwd_mask = 16'h8000; #1;
        checks++; if (fwd_hit !== 1'b1 || fwd_data !== 32'hAA) begin errors++; $display("FAIL wrap_fwd_old got hit=%0b data=%h want 1/aa", fwd_hit, fwd_data); end
        fwd_mask = '0;
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_forward();
        test_flush();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/store_queue.md
Name: store_queue

Overview:
- Parametrised circular store queue (STQ) for the out-of-order LSU.
- Allocates entries at dispatch and captures address and data from their execution paths.
- Marks entries committed in program order as the ROB retires them, then drains committed stores to memory over a valid/ready handshake.
- Answers a combinational store-to-load forwarding search driven by a load's store_mask; uncommitted entries are discarded on flush.

Parameters:
XLEN, 32, data/address width
ROB_TAG_WIDTH, 32, ROB tag width
STQ_SIZE, 16, entries; power of two, >=2
IDX_W, $clog2(STQ_SIZE), entry index width

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
alloc_valid  in  1  dispatch requests an entry
alloc_rob_tag  in  ROB_TAG_WIDTH  tag of allocating store
alloc_ready  out  1  queue not full
alloc_index  out  IDX_W  index granted (tail)
addr_valid  in  1  address write strobe
addr_index  in  IDX_W  target entry
addr_value  in  XLEN  store address
data_valid_in  in  1  data write strobe
data_index  in  IDX_W  target entry
data_value  in  XLEN  store data
commit_valid  in  1  ROB retires oldest uncommitted store
flush  in  1  discard all uncommitted entries
mem_req_valid  out  1  head entry ready to write memory
mem_req_addr  out  XLEN  head address
mem_req_data  out  XLEN  head data
mem_req_ready  in  1  memory accepts request
fwd_addr  in  XLEN  load address to search
fwd_mask  in  STQ_SIZE  older stores of the load
fwd_hit  out  1  matching store with data present
fwd_data  out  XLEN  forwarded data
fwd_stall  out  1  youngest match lacks data, or any masked entry has unknown address
full  out  1  all entries valid
empty  out  1  no entries valid

Behaviour:
- State: per-entry fields valid, address, address_valid, data, data_valid, committed, rob_tag; pointers head, commit_ptr, tail (IDX_W bits, wrap modulo STQ_SIZE); count (IDX_W+1 bits).
- Reset (async, reset_n low): all entry bits 0, pointers 0, count 0. Outputs: alloc_ready=1, full=0, empty=1, mem_req_valid=0, fwd_hit=0, fwd_stall=0, alloc_index=0.
- Alloc: on alloc_valid && alloc_ready at the clock edge:
  - write entry[tail] valid=1, rob_tag, all other flags 0;
  - tail+1; count+1.
  - alloc_ready = !full. An alloc while full is ignored.
- Address/data writes:
  - set address/address_valid or data/data_valid on the targeted entry next edge.
  - Writes to invalid entries are ignored.
  - Address and data writes to the same entry in the same cycle are both applied.
- Commit: commit_valid sets committed on entry[commit_ptr], commit_ptr+1.
  - Ignored if entry[commit_ptr] is not valid.
  - The ROB guarantees address_valid and data_valid are both set on the committing entry.
- Drain: mem_req_valid = entry[head].valid && committed; addr/data driven from entry[head].
  - On mem_req_valid && mem_req_ready: clear entry[head], head+1, count-1.
  - Once asserted, mem_req_valid and its payload stay stable until accepted (committed entries are never flushed).
- Same-cycle alloc and drain: count unchanged, both pointers move. Allocation is legal when full only if a drain occurs in that same cycle; alloc_ready remains the registered !full, so this case does not arise.
- Flush:
  - clears every valid && !committed entry;
  - tail <= commit_ptr; count <= committed entries remaining.
  - Flush has priority over alloc, addr, data and commit in the same cycle.
  - A drain handshake in the same cycle still completes.
- Forward (combinational):
  - candidates = fwd_mask & valid & address_valid & (address[XLEN-1:2] == fwd_addr[XLEN-1:2]).
  - Select the youngest candidate, scanning from tail-1 backwards toward head with wrap.
  - fwd_hit = selected.data_valid; fwd_data = selected.data, 0 when no hit.
  - fwd_stall = (any fwd_mask & valid & !address_valid) || (candidate exists && !selected.data_valid).
  - fwd_hit and fwd_stall are mutually exclusive; stall wins.
- Full and empty are derived from count.

Test Plan:
- Reset then 16 allocs (tags 0..15): alloc_index 0..15, full=1 after 16th, 17th alloc ignored, count stays 16.
- Alloc 1, addr 0x100, data 0xDEADBEEF, commit -> mem_req_valid next cycle with 0x100/0xDEADBEEF. Hold ready=0 for 3 cycles: payload stable. Ready=1 -> empty=1.
- Entries 0,1 both address 0x200 (data 0x11, 0x22); fwd_addr 0x202, mask 0b11 -> fwd_hit=1, fwd_data=0x22. Mask 0b01 -> 0x11.
- Entry 2 addr 0x300 without data; search 0x300, mask 0b100 -> fwd_stall=1, fwd_hit=0. Entry 3 without address, mask includes bit 3 -> fwd_stall=1.
- 5 allocs, commit 2, flush -> entries 2..4 invalid, tail=2, count=2. Drain of entry 0 in the flush cycle completes -> count=1.
- Fill, drain 4, alloc 4 more: tail wraps to 4. Youngest-match forwarding across the wrap selects the wrapped entry.
